// File: rtl/audiotypes_pkg.sv
// rtl/audiotypes_pkg.sv - shared audio RAM constants and decoder FSM state type
// Purpose: address width of the 8K x 16 audio sample RAM, the two audiomap
// buffer base addresses, and the state type of the decoder read FSM.
package audiotypes;

  localparam int          AUDIO_RAM_ADDR_W = 13;
  localparam logic [12:0] AUDIOMAP_BUF0    = 13'h1400;
  localparam logic [12:0] AUDIOMAP_BUF1    = 13'h1900;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    ACK  = 2'd2,
    ACKQ = 2'd3
  } dec_state_t;

endpackage

// File: rtl/audio_ram_bw.sv
// rtl/audio_ram_bw.sv - single-port 2**ADDR_W x 16 RAM with byte enables
// Purpose: inferred block RAM, one access per cycle, registered read data.
// Ports:
//   clk    in   clock
//   addr   in   word address (read and write)
//   we     in   write enable
//   be     in   byte enables, [1] = bits 15:8, [0] = bits 7:0
//   wdata  in   write data
//   rdata  out  mem[addr] from the previous cycle (old data on a write)
module audio_ram_bw
  import audiotypes::*;
#(
  parameter int ADDR_W = AUDIO_RAM_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/audio_buffer_responder.sv
// rtl/audio_buffer_responder.sv - audio sample RAM with host/decoder arbitration
// Purpose: responder end of the decoder's audio-buffer read interface. Owns the
// audio sample RAM and shares its single port between the decoder read stream
// and the host port; the host has priority, bounded by a starvation limit.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   mem_addr, mem_rd  decoder read request (level, held until mem_ack)
//   mem_data          decoder read data, valid with mem_ack, held afterwards
//   mem_ack           one-cycle strobe, 2 cycles after the decoder grant
//   mem_ack_q         mem_ack delayed by one cycle
//   host_addr/wdata/be/wr/rd  host request (level, held until host_ready)
//   host_ready        one-cycle strobe: host access granted
//   host_rdata        host read data, held until the next host read
//   host_rvalid       one-cycle strobe, 2 cycles after a read's host_ready
module audio_buffer_responder
  import audiotypes::*;
#(
  parameter int ADDR_W       = AUDIO_RAM_ADDR_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd,
  output logic [15:0]       mem_data,
  output logic              mem_ack,
  output logic              mem_ack_q,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_wdata,
  input  logic [1:0]        host_be,
  input  logic              host_wr,
  input  logic              host_rd,
  output logic              host_ready,
  output logic [15:0]       host_rdata,
  output logic              host_rvalid
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  dec_state_t        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              dec_cand;
  logic              host_cand;
  logic              dec_grant;
  logic              host_grant;
  logic              host_rd_inflight;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_rdata;

  // One grant per cycle. The granted address goes straight to the RAM, whose
  // registered read output is the captured sample; a host write in a later
  // cycle cannot disturb a read already issued.
  always_comb begin
    dec_cand   = mem_rd && (state == IDLE) && !reset;
    host_cand  = (host_wr || host_rd) && !reset;
    dec_grant  = dec_cand && (!host_cand || starve_cnt == CNT_W'(STARVE_LIMIT));
    host_grant = host_cand && !dec_grant;
    ram_addr   = dec_grant ? mem_addr : host_addr;
    ram_we     = host_grant && host_wr;
  end

  assign host_ready = host_grant;
  assign mem_ack    = (state == ACK);
  assign mem_ack_q  = (state == ACKQ);

  audio_ram_bw #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (host_be),
    .wdata (host_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      host_rd_inflight <= 1'b0;
      host_rvalid      <= 1'b0;
      host_rdata       <= '0;
      mem_data         <= '0;
    end else begin
      // RAM output ownership: a host read tag means the next ram_rdata is the
      // host's; otherwise only the decoder in RD1 consumes it.
      host_rd_inflight <= host_grant && host_rd;
      host_rvalid      <= host_rd_inflight;
      if (host_rd_inflight) host_rdata <= ram_rdata;

      if (!dec_cand || dec_grant) starve_cnt <= '0;
      else if (host_grant)        starve_cnt <= starve_cnt + CNT_W'(1);

      case (state)
        IDLE: if (dec_grant) state <= RD1;
        RD1: begin
          mem_data <= ram_rdata;
          state    <= ACK;
        end
        ACK:     state <= ACKQ;
        ACKQ:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_buffer_responder.sv
// tb/tb_audio_buffer_responder.sv - self-checking bench for audio_buffer_responder
module tb_audio_buffer_responder;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        mem_ack_q;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic [1:0]  host_be;
  logic        host_wr;
  logic        host_rd;
  logic        host_ready;
  logic [15:0] host_rdata;
  logic        host_rvalid;

  audio_buffer_responder #(.ADDR_W(13), .STARVE_LIMIT(STARVE)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .mem_ack_q  (mem_ack_q),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_be    (host_be),
    .host_wr    (host_wr),
    .host_rd    (host_rd),
    .host_ready (host_ready),
    .host_rdata (host_rdata),
    .host_rvalid(host_rvalid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Reference model: memory contents, cycle stamps of grants, pending host reads.
  typedef struct {
    int          cyc;
    logic [15:0] data;
  } hrd_t;

  logic [15:0] mdl [0:8191];
  hrd_t        hq[$];
  int          m_dgrant;
  int          m_dec_free;
  int          m_streak;
  logic [15:0] m_dec_val;
  logic [15:0] m_mem_data;
  logic [15:0] m_host_rdata;

  logic        s_host_ready, s_mem_ack, s_mem_ack_q, s_host_rvalid;
  logic [15:0] s_mem_data, s_host_rdata;

  task automatic model_reset();
    m_dgrant     = -100;
    m_dec_free   = 0;
    m_streak     = 0;
    m_dec_val    = '0;
    m_mem_data   = '0;
    m_host_rdata = '0;
    hq.delete();
  endtask

  // One clock cycle: sample at the falling edge, check against the model,
  // advance the model, return 1 time unit after the next rising edge.
  task automatic tick();
    logic dcand, hcand, dgr, hgr, rv;
    hrd_t e;
    @(negedge clk);
    s_host_ready  = host_ready;
    s_mem_ack     = mem_ack;
    s_mem_ack_q   = mem_ack_q;
    s_host_rvalid = host_rvalid;
    s_mem_data    = mem_data;
    s_host_rdata  = host_rdata;

    dcand = mem_rd && (cyc >= m_dec_free);
    hcand = host_wr || host_rd;
    dgr   = dcand && (!hcand || m_streak == STARVE);
    hgr   = hcand && !dgr;

    chk("host_ready", host_ready, hgr);
    chk("mem_ack", mem_ack, cyc == m_dgrant + 2);
    chk("mem_ack_q", mem_ack_q, cyc == m_dgrant + 3);
    if (cyc == m_dgrant + 2) m_mem_data = m_dec_val;
    chk("mem_data", mem_data, m_mem_data);
    rv = (hq.size() > 0) && (hq[0].cyc + 2 == cyc);
    if (rv) begin
      m_host_rdata = hq[0].data;
      void'(hq.pop_front());
    end
    chk("host_rvalid", host_rvalid, rv);
    chk("host_rdata", host_rdata, m_host_rdata);

    if (dgr) begin
      m_dgrant   = cyc;
      m_dec_free = cyc + 4;
      m_dec_val  = mdl[mem_addr];
      m_streak   = 0;
    end else if (!dcand) begin
      m_streak = 0;
    end
    if (hgr) begin
      if (dcand) m_streak++;
      if (host_wr) begin
        if (host_be[1]) mdl[host_addr][15:8] = host_wdata[15:8];
        if (host_be[0]) mdl[host_addr][7:0]  = host_wdata[7:0];
      end else begin
        e.cyc  = cyc;
        e.data = mdl[host_addr];
        hq.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [12:0] a, input logic [15:0] d, input logic [1:0] be);
    logic ok;
    ok = 1'b0;
    host_wr = 1'b1; host_addr = a; host_wdata = d; host_be = be;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      ok = s_host_ready;
    end
    host_wr = 1'b0;
    if (!ok) chk("host_write_timeout", 0, 1);
  endtask

  task automatic host_read(input logic [12:0] a, output logic [15:0] d);
    logic ok;
    int   lat;
    ok = 1'b0; lat = -1; d = '0;
    host_rd = 1'b1; host_addr = a;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      ok = s_host_ready;
    end
    host_rd = 1'b0;
    if (!ok) chk("host_read_timeout", 0, 1);
    for (int t = 0; t < 6 && lat < 0; t++) begin
      tick();
      if (s_host_rvalid) begin
        lat = t;
        d   = s_host_rdata;
      end
    end
    chk("host_rvalid_latency", lat, 1);
  endtask

  task automatic dec_read(input logic [12:0] a, output logic [15:0] d, output int lat);
    lat = -1; d = '0;
    mem_rd = 1'b1; mem_addr = a;
    for (int t = 0; t < 40 && lat < 0; t++) begin
      tick();
      if (s_mem_ack) begin
        lat = t;
        d   = s_mem_data;
      end
    end
    mem_rd = 1'b0;
    if (lat < 0) chk("dec_read_timeout", 0, 1);
    tick();
    chk("ack_q_follows", s_mem_ack_q, 1);
    chk("ack_q_data_held", s_mem_data, d);
  endtask

  function automatic logic [12:0] pool();
    if ($urandom_range(0, 8) == 0) return 13'h1FFF;
    return 13'h0010 + 13'($urandom_range(0, 7));
  endfunction

  typedef struct {
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t        vt [6];
    logic [15:0] d, d2;
    int          lat, gtick, atick, nh, rtick, t1, t2;
    logic        done, host_active, dec_active;

    vt[0] = '{13'h0010, 16'h1234, 2'b11, 16'h1234};
    vt[1] = '{13'h0010, 16'hAB00, 2'b10, 16'hAB34};
    vt[2] = '{13'h0010, 16'hFFFF, 2'b00, 16'hAB34};
    vt[3] = '{13'h0010, 16'h00CD, 2'b01, 16'hABCD};
    vt[4] = '{13'h1FFF, 16'h0F0F, 2'b11, 16'h0F0F};
    vt[5] = '{13'h1FFF, 16'hA5A5, 2'b01, 16'h0FA5};

    reset = 1'b1;
    mem_addr = '0; mem_rd = 1'b0;
    host_addr = '0; host_wdata = '0; host_be = '0; host_wr = 1'b0; host_rd = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("reset_mem_ack", mem_ack, 0);
    chk("reset_mem_ack_q", mem_ack_q, 0);
    chk("reset_host_rvalid", host_rvalid, 0);
    chk("reset_mem_data", mem_data, 0);
    chk("reset_host_rdata", host_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) tick();

    // Read after write at audiomap buffer 0.
    host_write(13'h1400, 16'hBEEF, 2'b11);
    dec_read(13'h1400, d, lat);
    chk("raw_latency", lat, 2);
    chk("raw_data", d, 16'hBEEF);

    // Byte-enable table.
    for (int i = 0; i < 6; i++) begin
      host_write(vt[i].addr, vt[i].wdata, vt[i].be);
      host_read(vt[i].addr, d);
      chk($sformatf("be_vec%0d", i), d, vt[i].exp);
    end
    dec_read(13'h0010, d, lat);
    chk("be_dec_read", d, 16'hABCD);

    host_write(13'h1900, 16'h1919, 2'b11);
    host_write(13'h1FFE, 16'h1EEE, 2'b11);
    host_write(13'h0020, 16'h5555, 2'b11);
    host_write(13'h0021, 16'hAAAA, 2'b11);

    // Starvation bound: host writes held continuously against a decoder read.
    gtick = -1; atick = -1; nh = 0; done = 1'b0; d = '0;
    host_wr = 1'b1; host_addr = 13'h0000; host_wdata = 16'h7000; host_be = 2'b11;
    mem_rd = 1'b1; mem_addr = 13'h1900;
    for (int t = 0; t < 30 && !done; t++) begin
      tick();
      if (!s_host_ready && gtick < 0) gtick = t;
      if (s_host_ready && gtick < 0) nh++;
      if (s_mem_ack) begin
        atick = t; d = s_mem_data; mem_rd = 1'b0;
      end
      if (s_host_ready) begin
        if (atick >= 0) begin
          host_wr = 1'b0; done = 1'b1;
        end else begin
          host_addr = host_addr + 13'd1; host_wdata = host_wdata + 16'd1;
        end
      end
    end
    host_wr = 1'b0; mem_rd = 1'b0;
    chk("starve_grant_tick", gtick, 3);
    chk("starve_host_grants", nh, 3);
    chk("starve_ack_tick", atick, 5);
    chk("starve_data", d, 16'h1919);
    repeat (2) tick();

    // Back-to-back decoder reads at the top of the address space.
    t1 = -1; t2 = -1; d = '0; d2 = '0;
    mem_rd = 1'b1; mem_addr = 13'h1FFE;
    for (int t = 0; t < 30 && t2 < 0; t++) begin
      tick();
      if (s_mem_ack) begin
        if (t1 < 0) begin
          t1 = t; d = s_mem_data; mem_addr = 13'h1FFF;
        end else begin
          t2 = t; d2 = s_mem_data; mem_rd = 1'b0;
        end
      end
    end
    mem_rd = 1'b0;
    chk("b2b_first_latency", t1, 2);
    chk("b2b_period", t2 - t1, 4);
    chk("b2b_data0", d, 16'h1EEE);
    chk("b2b_data1", d2, 16'h0FA5);
    repeat (2) tick();

    // Host read and decoder read overlapping in the RAM pipeline.
    rtick = -1; atick = -1; d = '0; d2 = '0;
    host_rd = 1'b1; host_addr = 13'h0020;
    mem_rd = 1'b1; mem_addr = 13'h0021;
    for (int t = 0; t < 20 && (rtick < 0 || atick < 0); t++) begin
      tick();
      if (s_host_ready) host_rd = 1'b0;
      if (s_host_rvalid) begin
        rtick = t; d = s_host_rdata;
      end
      if (s_mem_ack) begin
        atick = t; d2 = s_mem_data; mem_rd = 1'b0;
      end
    end
    host_rd = 1'b0; mem_rd = 1'b0;
    chk("concur_rvalid_tick", rtick, 2);
    chk("concur_ack_tick", atick, 3);
    chk("concur_host_data", d, 16'h5555);
    chk("concur_dec_data", d2, 16'hAAAA);
    repeat (2) tick();

    // Reset asserted while the decoder is in RD1.
    mem_rd = 1'b1; mem_addr = 13'h0020;
    tick();
    host_wr = 1'b1; host_be = 2'b00; host_addr = 13'h0030;
    reset = 1'b1;
    #1;
    chk("rst_mem_ack", mem_ack, 0);
    chk("rst_mem_ack_q", mem_ack_q, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_mem_data", mem_data, 0);
    @(posedge clk); #1;
    host_wr = 1'b0; mem_rd = 1'b0; reset = 1'b0;
    model_reset();
    nh = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (s_mem_ack || s_mem_ack_q) nh++;
    end
    chk("rst_no_ack", nh, 0);
    dec_read(13'h0020, d, lat);
    chk("rst_fresh_latency", lat, 2);
    chk("rst_fresh_data", d, 16'h5555);

    // Randomized traffic against the model.
    for (int a = 16; a < 24; a++) host_write(13'(a), 16'($urandom), 2'b11);
    host_active = 1'b0; dec_active = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!host_active && $urandom_range(0, 3) != 0) begin
        host_active = 1'b1;
        host_addr   = pool();
        host_wdata  = 16'($urandom);
        host_be     = 2'($urandom);
        if ($urandom_range(0, 1) == 1) host_wr = 1'b1;
        else                           host_rd = 1'b1;
      end
      if (!dec_active && $urandom_range(0, 2) == 0) begin
        dec_active = 1'b1; mem_rd = 1'b1; mem_addr = pool();
      end
      tick();
      if (s_host_ready) begin
        host_wr = 1'b0; host_rd = 1'b0; host_active = 1'b0;
      end
      if (s_mem_ack) begin
        if ($urandom_range(0, 1) == 1) mem_addr = pool();
        else begin
          mem_rd = 1'b0; dec_active = 1'b0;
        end
      end
    end
    for (int t = 0; t < 60 && (host_active || dec_active); t++) begin
      tick();
      if (s_host_ready) begin
        host_wr = 1'b0; host_rd = 1'b0; host_active = 1'b0;
      end
      if (s_mem_ack) begin
        mem_rd = 1'b0; dec_active = 1'b0;
      end
    end
    chk("random_drain", {30'd0, host_active, dec_active}, 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
